// File: rtl/tc_fp_pkg.sv
// Shared floating-point helpers for the tensor-core datapath (tc_mul, tc_add).
// Contents:
//   RM_*   rounding-mode encodings
//   FF_*   bit positions inside the 5-bit fflags vector
//   exp_max, bias, qnan  format helpers, all usable in constant expressions
package tc_fp_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RUP = 3'b010;
    localparam logic [2:0] RM_RDN = 3'b011;

    localparam int unsigned FF_NV = 4;
    localparam int unsigned FF_OF = 3;
    localparam int unsigned FF_UF = 2;
    localparam int unsigned FF_DZ = 1;
    localparam int unsigned FF_NX = 0;

    // All-ones exponent value, reserved for Inf/NaN.
    function automatic int unsigned exp_max(input int unsigned ew);
        return (32'd1 << ew) - 32'd1;
    endfunction

    function automatic int unsigned bias(input int unsigned ew);
        return (32'd1 << (ew - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits.
    function automatic logic [63:0] qnan(input int unsigned ew, input int unsigned fw);
        logic [63:0] r;
        r = ((64'd1 << ew) - 64'd1) << fw;
        r = r | (64'd1 << (fw - 32'd1));
        return r;
    endfunction

endpackage

// File: rtl/tc_round.sv
// Combinational rounding-increment unit, shared by tc_mul and tc_add.
// Ports:
//   i_mant  significand to round (hidden bit included)
//   i_g     guard bit (first bit below the kept LSB)
//   i_s     sticky bit (OR of everything below the guard)
//   i_sign  sign of the value being rounded
//   i_rm    rounding mode (unknown encodings behave as RNE)
//   o_mant  rounded significand
//   o_carry carry out of the significand increment
module tc_round
    import tc_fp_pkg::*;
#(
    parameter int unsigned MW = 9
) (
    input  logic [MW-1:0] i_mant,
    input  logic          i_g,
    input  logic          i_s,
    input  logic          i_sign,
    input  logic [2:0]    i_rm,
    output logic [MW-1:0] o_mant,
    output logic          o_carry
);

    logic w_inc;

    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RUP:  w_inc = ~i_sign & (i_g | i_s);
            RM_RDN:  w_inc = i_sign & (i_g | i_s);
            default: w_inc = i_g & (i_s | i_mant[0]);
        endcase
    end

    assign {o_carry, o_mant} = {1'b0, i_mant} + {{MW{1'b0}}, w_inc};

endmodule

// File: rtl/tc_mul.sv
// Two-stage pipelined FP multiplier feeding the tc_add adder tree.
// Inputs are {sign, exp[EXPWIDTH-1:0], frac[INPC-1:0]}; the product is returned in the
// wider adder operand format {sign, exp[EXPWIDTH-1:0], frac[PRECISION-1:0]}.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en_i          pipeline advance; 0 freezes every register including outputs
//   valid_i       operand pair valid
//   rm_i          rounding mode (RNE/RTZ/RUP/RDN, others RNE)
//   a_i, b_i      operands
//   out_valid_o   result valid, 2 enabled edges after valid_i
//   out_result_o  registered product
//   out_fflags_o  {NV, OF, UF, DZ(0), NX}
module tc_mul
    import tc_fp_pkg::*;
#(
    parameter int unsigned EXPWIDTH  = 5,
    parameter int unsigned INPC      = 4,
    parameter int unsigned PRECISION = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          valid_i,
    input  logic [2:0]                    rm_i,
    input  logic [EXPWIDTH+INPC:0]        a_i,
    input  logic [EXPWIDTH+INPC:0]        b_i,
    output logic                          out_valid_o,
    output logic [EXPWIDTH+PRECISION:0]   out_result_o,
    output logic [4:0]                    out_fflags_o
);

    localparam int unsigned PW  = 2 * INPC + 2;       // significand product width
    localparam int unsigned LZW = $clog2(PW + 1);
    localparam int unsigned EW  = EXPWIDTH + 2;       // registered exponent sum
    localparam int unsigned XW  = EXPWIDTH + 3;       // headroom for normalisation
    localparam int unsigned WW  = PRECISION + 3;      // hidden + frac + guard + 1 spare
    localparam int unsigned MW  = PRECISION + 1;
    localparam int unsigned OW  = 1 + EXPWIDTH + PRECISION;

    localparam logic [EXPWIDTH-1:0] EMAX   = EXPWIDTH'(exp_max(EXPWIDTH));
    localparam logic [XW-1:0]       EMAX_X = XW'(exp_max(EXPWIDTH));
    localparam logic [EW-1:0]       BIAS_E = EW'(bias(EXPWIDTH));
    localparam logic [OW-1:0]       QNAN   = OW'(qnan(EXPWIDTH, PRECISION));

    if (PRECISION < 2 * INPC) begin : g_bad_precision
        $fatal(1, "tc_mul: PRECISION must be >= 2*INPC");
    end

    function automatic logic [LZW-1:0] lzc(input logic [PW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(PW);
        for (int i = 0; i < int'(PW); i++) begin
            if (v[i]) n = LZW'(PW - 1 - i);
        end
        return n;
    endfunction

    // ---------------- Stage 1: unpack and significand product ----------------
    logic [EXPWIDTH-1:0] w_a_exp, w_b_exp, w_a_eff, w_b_eff;
    logic [INPC-1:0]     w_a_frac, w_b_frac;
    logic [INPC:0]       w_a_sig, w_b_sig;
    logic [PW-1:0]       w_prod;
    logic [EW-1:0]       w_esum;

    assign w_a_exp  = a_i[EXPWIDTH+INPC-1:INPC];
    assign w_b_exp  = b_i[EXPWIDTH+INPC-1:INPC];
    assign w_a_frac = a_i[INPC-1:0];
    assign w_b_frac = b_i[INPC-1:0];
    assign w_a_sig  = {|w_a_exp, w_a_frac};
    assign w_b_sig  = {|w_b_exp, w_b_frac};
    // Subnormals use exponent 1 with hidden bit 0.
    assign w_a_eff  = (w_a_exp == '0) ? EXPWIDTH'(1) : w_a_exp;
    assign w_b_eff  = (w_b_exp == '0) ? EXPWIDTH'(1) : w_b_exp;
    assign w_prod   = PW'(w_a_sig) * PW'(w_b_sig);
    assign w_esum   = EW'(w_a_eff) + EW'(w_b_eff) - BIAS_E;

    logic          r_s1_valid, r_s1_sign;
    logic [2:0]    r_s1_rm;
    logic [PW-1:0] r_s1_prod;
    logic [EW-1:0] r_s1_esum;
    logic          r_s1_a_nan, r_s1_a_inf, r_s1_a_zero;
    logic          r_s1_b_nan, r_s1_b_inf, r_s1_b_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_rm     <= '0;
            r_s1_prod   <= '0;
            r_s1_esum   <= '0;
            r_s1_a_nan  <= 1'b0;
            r_s1_a_inf  <= 1'b0;
            r_s1_a_zero <= 1'b0;
            r_s1_b_nan  <= 1'b0;
            r_s1_b_inf  <= 1'b0;
            r_s1_b_zero <= 1'b0;
        end else if (en_i) begin
            r_s1_valid  <= valid_i;
            r_s1_sign   <= a_i[EXPWIDTH+INPC] ^ b_i[EXPWIDTH+INPC];
            r_s1_rm     <= rm_i;
            r_s1_prod   <= w_prod;
            r_s1_esum   <= w_esum;
            r_s1_a_nan  <= (&w_a_exp) & (|w_a_frac);
            r_s1_a_inf  <= (&w_a_exp) & ~(|w_a_frac);
            r_s1_a_zero <= ~(|w_a_exp) & ~(|w_a_frac);
            r_s1_b_nan  <= (&w_b_exp) & (|w_b_frac);
            r_s1_b_inf  <= (&w_b_exp) & ~(|w_b_frac);
            r_s1_b_zero <= ~(|w_b_exp) & ~(|w_b_frac);
        end
    end

    // ---------------- Stage 2: normalise, round, pack ----------------
    logic [LZW-1:0]       w_lz;
    logic [PW-1:0]        w_norm;
    logic signed [XW-1:0] w_exp_adj;
    logic [XW-1:0]        w_sh_amt, w_exp_pre, w_exp_fin;
    logic [WW-1:0]        w_work, w_aligned;
    logic                 w_sticky, w_inexact;
    logic [MW-1:0]        w_mant_rnd;
    logic                 w_carry;
    logic [OW-1:0]        w_result;
    logic [4:0]           w_fflags;

    always_comb begin
        // Shift the product so its leading one sits in the MSB; the MSB is the
        // hidden-bit position, so the exponent gains 1 and loses the shift.
        w_lz      = lzc(r_s1_prod);
        w_norm    = r_s1_prod << w_lz;
        w_exp_adj = $signed({{(XW - EW){r_s1_esum[EW-1]}}, r_s1_esum})
                    + $signed(XW'(1)) - $signed(XW'(w_lz));
        w_work    = WW'(w_norm) << (WW - PW);
        w_aligned = w_work;
        w_sticky  = 1'b0;
        w_sh_amt  = '0;
        w_exp_pre = w_exp_adj;
        if (w_exp_adj[XW-1] || (w_exp_adj == '0)) begin
            // Below the normal range: denormalise into the exp=0 encoding.
            w_sh_amt  = XW'(1) - w_exp_adj;
            w_exp_pre = '0;
            if (w_sh_amt >= XW'(WW)) begin
                w_sticky  = |w_work;
                w_aligned = '0;
            end else begin
                w_sticky  = |(w_work & ~({WW{1'b1}} << w_sh_amt));
                w_aligned = w_work >> w_sh_amt;
            end
        end
    end

    tc_round #(
        .MW (MW)
    ) u_round (
        .i_mant  (w_aligned[WW-1:2]),
        .i_g     (w_aligned[1]),
        .i_s     (w_aligned[0] | w_sticky),
        .i_sign  (r_s1_sign),
        .i_rm    (r_s1_rm),
        .o_mant  (w_mant_rnd),
        .o_carry (w_carry)
    );

    always_comb begin
        w_inexact = w_aligned[1] | w_aligned[0] | w_sticky;
        // Carry-out leaves frac=0 and bumps the exponent; a subnormal that
        // rounds up into the hidden bit becomes the smallest normal.
        w_exp_fin = w_exp_pre + XW'(w_carry);
        if ((w_exp_pre == '0) && w_mant_rnd[MW-1]) w_exp_fin = XW'(1);

        w_result         = {r_s1_sign, w_exp_fin[EXPWIDTH-1:0], w_mant_rnd[PRECISION-1:0]};
        w_fflags         = '0;
        w_fflags[FF_NX]  = w_inexact;
        w_fflags[FF_UF]  = w_inexact & (w_exp_fin == '0);
        if (w_exp_fin >= EMAX_X) begin
            w_result        = {r_s1_sign, EMAX, {PRECISION{1'b0}}};
            w_fflags        = '0;
            w_fflags[FF_OF] = 1'b1;
            w_fflags[FF_NX] = 1'b1;
        end

        if (r_s1_a_nan || r_s1_b_nan) begin
            w_result = QNAN;
            w_fflags = '0;
        end else if ((r_s1_a_inf && r_s1_b_zero) || (r_s1_b_inf && r_s1_a_zero)) begin
            w_result        = QNAN;
            w_fflags        = '0;
            w_fflags[FF_NV] = 1'b1;
        end else if (r_s1_a_inf || r_s1_b_inf) begin
            w_result = {r_s1_sign, EMAX, {PRECISION{1'b0}}};
            w_fflags = '0;
        end else if (r_s1_a_zero || r_s1_b_zero) begin
            w_result = {r_s1_sign, {(OW - 1){1'b0}}};
            w_fflags = '0;
        end
    end

    logic          r_out_valid;
    logic [OW-1:0] r_out_result;
    logic [4:0]    r_out_fflags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_fflags <= '0;
        end else if (en_i) begin
            r_out_valid  <= r_s1_valid;
            r_out_result <= w_result;
            r_out_fflags <= w_fflags;
        end
    end

    assign out_valid_o  = r_out_valid;
    assign out_result_o = r_out_result;
    assign out_fflags_o = r_out_fflags;

endmodule

// File: tb/tb_tc_mul.sv
// Self-checking bench for tc_mul with default parameters (10-bit operands,
// 14-bit result). Directed cases, then random operands against an exact
// value-based reference, a stalled stream and a mid-flight reset.
module tb_tc_mul;

    localparam int P    = 8;
    localparam int BIAS = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        valid_i;
    logic [2:0]  rm_i;
    logic [9:0]  a_i, b_i;
    logic        out_valid_o;
    logic [13:0] out_result_o;
    logic [4:0]  out_fflags_o;

    int n_assert = 0;
    int n_fail   = 0;
    int nvalid   = 0;

    logic [9:0]  s_a [4];
    logic [9:0]  s_b [4];
    logic [2:0]  s_rm [4];
    logic [13:0] s_res [4];
    logic [4:0]  s_ff [4];

    always #5 clk = ~clk;

    tc_mul #(
        .EXPWIDTH  (5),
        .INPC      (4),
        .PRECISION (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .valid_i      (valid_i),
        .rm_i         (rm_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .out_valid_o  (out_valid_o),
        .out_result_o (out_result_o),
        .out_fflags_o (out_fflags_o)
    );

    // Exact reference: value = n * 2^k; pick the quantum of the target binade
    // (or of the subnormal range), then round the remainder against half a quantum.
    function automatic void model(input logic [9:0] a, input logic [9:0] b,
                                  input logic [2:0] rm,
                                  output logic [13:0] res, output logic [4:0] ff);
        int ea, eb, fa, fb, k, p, be, q, d;
        longint n, m, rem, half, one;
        logic sgn, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, inexact, up;
        ea = int'(a[8:4]); fa = int'(a[3:0]);
        eb = int'(b[8:4]); fb = int'(b[3:0]);
        sgn    = a[9] ^ b[9];
        nan_a  = (ea == 31) && (fa != 0);
        nan_b  = (eb == 31) && (fb != 0);
        inf_a  = (ea == 31) && (fa == 0);
        inf_b  = (eb == 31) && (fb == 0);
        zero_a = (ea == 0) && (fa == 0);
        zero_b = (eb == 0) && (fb == 0);
        res = '0;
        ff  = '0;
        one = 1;
        if (nan_a || nan_b) begin
            res = 14'h1F80;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            res = 14'h1F80;
            ff  = 5'h10;
        end else if (inf_a || inf_b) begin
            res = {sgn, 5'h1F, 8'h00};
        end else if (zero_a || zero_b) begin
            res = {sgn, 13'h0};
        end else begin
            n = longint'(((ea != 0) ? fa + 16 : fa) * ((eb != 0) ? fb + 16 : fb));
            k = ((ea != 0) ? ea : 1) + ((eb != 0) ? eb : 1) - 2 * BIAS - 8;
            p = 0;
            for (int i = 0; i < 12; i++) if (n[i]) p = i;
            be = p + k + BIAS;
            if (be < 1) be = 1;
            q = be - BIAS - P;
            d = q - k;
            if (d <= 0) begin
                m = n << (-d); rem = 0; half = 0;
            end else begin
                m = n >> d; rem = n & ((one << d) - 1); half = one << (d - 1);
            end
            inexact = (rem != 0);
            case (rm)
                3'b001:  up = 1'b0;
                3'b010:  up = !sgn && inexact;
                3'b011:  up = sgn && inexact;
                default: up = (rem > half) || ((rem == half) && inexact && m[0]);
            endcase
            if (up) m = m + 1;
            if (m == (one << (P + 1))) begin m = m >> 1; be = be + 1; end
            if (m < (one << P)) be = 0;
            if (be >= 31) begin
                res = {sgn, 5'h1F, 8'h00};
                ff  = 5'h09;
            end else begin
                res   = {sgn, be[4:0], m[7:0]};
                ff[0] = inexact;
                ff[2] = inexact && (be == 0);
            end
        end
    endfunction

    function automatic logic [9:0] rnd_op();
        logic [9:0] v;
        v = 10'($urandom);
        case ($urandom_range(0, 3))
            1:       v[8:4] = 5'($urandom_range(0, 4));
            2:       v[8:4] = 5'($urandom_range(26, 30));
            3:       v[8:4] = 5'($urandom_range(12, 18));
            default: ;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic [9:0] b,
                         input logic [2:0] rm);
        valid_i = v; a_i = a; b_i = b; rm_i = rm;
    endtask

    task automatic chk_valid(input string tag, input logic v);
        n_assert++;
        assert (out_valid_o === v) else begin
            n_fail++;
            $error("FAIL %s valid: got %b want %b", tag, out_valid_o, v);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [13:0] r,
                           input logic [4:0] f);
        chk_valid(tag, v);
        n_assert++;
        assert (out_result_o === r) else begin
            n_fail++;
            $error("FAIL %s result: got %h want %h", tag, out_result_o, r);
        end
        n_assert++;
        assert (out_fflags_o === f) else begin
            n_fail++;
            $error("FAIL %s fflags: got %h want %h", tag, out_fflags_o, f);
        end
    endtask

    // Issue one op, confirm nothing valid after 1 edge, full check after 2.
    task automatic run_op(input string tag, input logic [9:0] a, input logic [9:0] b,
                          input logic [2:0] rm, input logic [13:0] r, input logic [4:0] f);
        drive(1'b1, a, b, rm);
        step();
        drive(1'b0, 10'h0, 10'h0, 3'b000);
        chk_valid({tag, "_lat1"}, 1'b0);
        step();
        chk_out(tag, 1'b1, r, f);
    endtask

    task automatic stream_pop(input string tag);
        if (out_valid_o === 1'b1) begin
            n_assert++;
            assert (nvalid < 4) else begin
                n_fail++;
                $error("FAIL %s extra valid: got %0d want <4", tag, nvalid);
            end
            if (nvalid < 4) chk_out(tag, 1'b1, s_res[nvalid], s_ff[nvalid]);
            nvalid++;
        end
    endtask

    initial begin
        logic [9:0]  ra, rb;
        logic [2:0]  rrm;
        logic [13:0] er;
        logic [4:0]  ef;

        rst_n = 1'b0; en_i = 1'b0;
        drive(1'b0, 10'h0, 10'h0, 3'b000);
        #12;
        chk_out("reset", 1'b0, 14'h0, 5'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en_i  = 1'b1;

        run_op("one_x_one",  10'h0F0, 10'h0F0, 3'b000, 14'h0F00, 5'h00);
        run_op("1p5_sq",     10'h0F8, 10'h0F8, 3'b000, 14'h1020, 5'h00);
        run_op("max_sq_rne", 10'h0FF, 10'h0FF, 3'b000, 14'h10E0, 5'h01);
        run_op("max_sq_rup", 10'h0FF, 10'h0FF, 3'b010, 14'h10E1, 5'h01);
        run_op("overflow",   10'h1EF, 10'h1EF, 3'b000, 14'h1F00, 5'h09);
        run_op("inf_x_zero", 10'h1F0, 10'h000, 3'b000, 14'h1F80, 5'h10);

        for (int i = 0; i < 80; i++) begin
            ra  = rnd_op();
            rb  = rnd_op();
            rrm = 3'($urandom_range(0, 7));
            model(ra, rb, rrm, er, ef);
            run_op($sformatf("rand%0d_%h_%h_rm%0d", i, ra, rb, rrm), ra, rb, rrm, er, ef);
        end

        // Back-to-back stream with a 3-cycle stall after the third pair.
        for (int i = 0; i < 4; i++) begin
            s_a[i]  = rnd_op();
            s_b[i]  = rnd_op();
            s_rm[i] = 3'($urandom_range(0, 3));
            model(s_a[i], s_b[i], s_rm[i], s_res[i], s_ff[i]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s_a[i], s_b[i], s_rm[i]);
            step();
            stream_pop("stream");
        end
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_op(), rnd_op(), 3'b000);
            step();
            chk_out("stall_hold", 1'b1, s_res[1], s_ff[1]);
        end
        en_i = 1'b1;
        drive(1'b1, s_a[3], s_b[3], s_rm[3]);
        step();
        stream_pop("stream");
        drive(1'b0, 10'h0, 10'h0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step();
            stream_pop("stream");
        end
        n_assert++;
        assert (nvalid == 4) else begin
            n_fail++;
            $error("FAIL stream_count: got %0d want 4", nvalid);
        end

        // Reset while two pairs are in flight.
        drive(1'b1, 10'h0F8, 10'h0F8, 3'b000);
        step();
        drive(1'b1, 10'h0F0, 10'h0F0, 3'b000);
        step();
        drive(1'b0, 10'h0, 10'h0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 14'h0, 5'h0);
        step();
        chk_out("rst_held", 1'b0, 14'h0, 5'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_valid("post_rst_idle", 1'b0);
        end
        run_op("post_rst_op", 10'h0F8, 10'h0F8, 3'b000, 14'h1020, 5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
